ropuf_eval_ctrl: RTL and testbench

ROPUF_EVAL_CTRL -- requirements
Module: ropuf_eval_ctrl

---
 rtl/ropuf_eval_ctrl.sv | 154 +++++++++++++++
 tb/tb_ropuf_eval_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ropuf_eval_ctrl.sv
// ============================================================================
// Module  : ropuf_eval_ctrl
// Brief   : Ring-oscillator PUF evaluation sequencer producing a 2-bit response
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ropuf_eval_ctrl #(
  parameter int unsigned WINDOW = 8,
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] challenge,
  output logic       req_ready,
  output logic [1:0] ro_sel,
  output logic       ro_en,
  output logic       cnt_clr,
  input  logic [3:0] count0,
  input  logic [3:0] count1,
  output logic [1:0] resp,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       sat_err,
  output logic       busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLEAR   = 3'd1,
    S_RUN     = 3'd2,
    S_SETTLE  = 3'd3,
    S_COMPARE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic       idx_q, idx_d;
  logic [3:0] chal_q, chal_d;
  logic [1:0] resp_q, resp_d;
  logic       sat_err_q, sat_err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       req_ready_q, req_ready_d;
  logic [1:0] ro_sel_q, ro_sel_d;
  logic       ro_en_q, ro_en_d;
  logic       cnt_clr_q, cnt_clr_d;
  logic       resp_valid_q, resp_valid_d;
  logic       busy_q, busy_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chal_d    = chal_q;
    resp_d    = resp_q;
    sat_err_d = sat_err_q;
    cnt_d     = cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && req_ready_q) begin
          state_d   = S_CLEAR;
          idx_d     = 1'b0;
          chal_d    = challenge;
          resp_d    = 2'b00;
          sat_err_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_RUN;
        cnt_d   = 8'(WINDOW - 1);
      end
      S_RUN: begin
        if (cnt_q == 8'd0) begin
          state_d = S_SETTLE;
          cnt_d   = 8'(SETTLE - 1);
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == 8'd0) state_d = S_COMPARE;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_COMPARE: begin
        resp_d[idx_q] = (count0 > count1);
        if ((count0 == 4'hF) || (count1 == 4'hF)) sat_err_d = 1'b1;
        if (idx_q) begin
          state_d = S_DONE;
        end else begin
          idx_d   = 1'b1;
          state_d = S_CLEAR;
        end
      end
      S_DONE: begin
        // Handshake only counts once resp_valid is actually visible.
        if (resp_valid_q && resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs follow the next state so they line up with the state register.
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    cnt_clr_d    = (state_d == S_CLEAR);
    ro_en_d      = (state_d == S_RUN);
    ro_sel_d     = 2'b00;
    if (state_d inside {S_CLEAR, S_RUN, S_SETTLE, S_COMPARE})
      ro_sel_d = idx_d ? chal_d[3:2] : chal_d[1:0];
    resp_valid_d = (state_q == S_DONE) && (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= 1'b0;
      chal_q       <= 4'h0;
      resp_q       <= 2'b00;
      sat_err_q    <= 1'b0;
      cnt_q        <= 8'd0;
      req_ready_q  <= 1'b1;
      ro_sel_q     <= 2'b00;
      ro_en_q      <= 1'b0;
      cnt_clr_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      chal_q       <= chal_d;
      resp_q       <= resp_d;
      sat_err_q    <= sat_err_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      ro_sel_q     <= ro_sel_d;
      ro_en_q      <= ro_en_d;
      cnt_clr_q    <= cnt_clr_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign ro_sel     = ro_sel_q;
  assign ro_en      = ro_en_q;
  assign cnt_clr    = cnt_clr_q;
  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
  assign sat_err    = sat_err_q;
  assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_ropuf_eval_ctrl.sv
// ============================================================================
// Module  : tb_ropuf_eval_ctrl
// Brief   : Self-checking bench for ropuf_eval_ctrl against a timing-formula model
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ropuf_eval_ctrl;

  localparam int WINDOW = 8;
  localparam int SETTLE = 2;
  localparam int PH     = 2 + WINDOW + SETTLE;  // cycles per response bit
  localparam int LAT    = 2 * PH + 1;           // acceptance to resp_valid

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [3:0] challenge;
  logic       req_ready;
  logic [1:0] ro_sel;
  logic       ro_en;
  logic       cnt_clr;
  logic [3:0] count0;
  logic [3:0] count1;
  logic [1:0] resp;
  logic       resp_valid;
  logic       resp_ready;
  logic       sat_err;
  logic       busy;

  logic [3:0] c0_tab [4];
  logic [3:0] c1_tab [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Idealised counter datapath: each pair reports a fixed edge count.
  assign count0 = c0_tab[ro_sel];
  assign count1 = c1_tab[ro_sel];

  ropuf_eval_ctrl #(.WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
    .clk(clk), .reset(reset), .start(start), .challenge(challenge),
    .req_ready(req_ready), .ro_sel(ro_sel), .ro_en(ro_en), .cnt_clr(cnt_clr),
    .count0(count0), .count1(count1), .resp(resp), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .sat_err(sat_err), .busy(busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] ctl_now();
    return {cnt_clr, ro_en, ro_sel, busy, req_ready, resp_valid};
  endfunction

  // Expected {cnt_clr, ro_en, ro_sel, busy, req_ready, resp_valid} k edges after acceptance.
  function automatic logic [6:0] exp_ctl(int k, logic [3:0] ch);
    int         b, o;
    logic       clr, en;
    logic [1:0] sel;
    clr = 1'b0; en = 1'b0; sel = 2'b00;
    if (k < 2 * PH) begin
      b   = k / PH;
      o   = k % PH;
      clr = (o == 0);
      en  = (o >= 1) && (o <= WINDOW);
      sel = (b != 0) ? ch[3:2] : ch[1:0];
    end
    return {clr, en, sel, 1'b1, 1'b0, (k >= LAT)};
  endfunction

  // Expected {resp, sat_err} k edges after acceptance.
  function automatic logic [2:0] exp_res(int k, logic [3:0] ch);
    logic r0, r1, s0, s1;
    r0 = c0_tab[ch[1:0]] > c1_tab[ch[1:0]];
    r1 = c0_tab[ch[3:2]] > c1_tab[ch[3:2]];
    s0 = (c0_tab[ch[1:0]] == 4'hF) || (c1_tab[ch[1:0]] == 4'hF);
    s1 = (c0_tab[ch[3:2]] == 4'hF) || (c1_tab[ch[3:2]] == 4'hF);
    if (k < PH)          return 3'b000;
    else if (k < 2 * PH) return {1'b0, r0, s0};
    else                 return {r1, r0, s0 | s1};
  endfunction

  task automatic run_eval(input logic [3:0] ch, input int hold);
    int last;
    int first_rv;
    last     = LAT + hold;
    first_rv = -1;
    @(negedge clk);
    start     = 1'b1;
    challenge = ch;
    @(posedge clk); #1;
    for (int k = 0; k <= last; k++) begin
      check_eq("ctl", 32'(ctl_now()), 32'(exp_ctl(k, ch)));
      check_eq("res", 32'({resp, sat_err}), 32'(exp_res(k, ch)));
      if (resp_valid && first_rv < 0) first_rv = k;
      @(negedge clk);
      start      = (k == last) ? 1'b0 : 1'($urandom_range(0, 1));
      challenge  = 4'($urandom);
      resp_ready = (k < 2 * PH) ? 1'($urandom_range(0, 1)) : (k == last);
      @(posedge clk); #1;
    end
    check_eq("latency", 32'(first_rv), 32'(LAT));
    check_eq("idle_ctl", 32'(ctl_now()), 32'(7'b0000010));
    check_eq("idle_res", 32'({resp, sat_err}), 32'(exp_res(last, ch)));
    @(negedge clk);
    resp_ready = 1'b0;
    start      = 1'b0;
  endtask

  task automatic abort_eval(input logic [3:0] ch);
    @(negedge clk);
    start     = 1'b1;
    challenge = ch;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (PH + 3) @(posedge clk);
    #1;
    check_eq("pre_rst_ctl", 32'(ctl_now()), 32'(exp_ctl(PH + 3, ch)));
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_ctl", 32'({cnt_clr, ro_en, ro_sel, busy, resp_valid}), 32'(0));
    check_eq("rst_res", 32'({resp, sat_err}), 32'(0));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check_eq("rst_hold_valid", 32'({resp_valid, busy}), 32'(0));
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("rst_rel_ctl", 32'(ctl_now()), 32'(7'b0000010));
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    challenge  = 4'h0;
    resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      c0_tab[i] = 4'h0;
      c1_tab[i] = 4'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_ctl", 32'({cnt_clr, ro_en, ro_sel, busy, resp_valid}), 32'(0));
    check_eq("reset_res", 32'({resp, sat_err}), 32'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq("post_reset_ctl", 32'(ctl_now()), 32'(7'b0000010));

    // Pair 1: 9 vs 5, pair 2: 3 vs 7, long hold in DONE.
    c0_tab[1] = 4'd9; c1_tab[1] = 4'd5;
    c0_tab[2] = 4'd3; c1_tab[2] = 4'd7;
    run_eval(4'b1001, 10);
    check_eq("dir_resp", 32'({resp, sat_err}), 32'(3'b010));

    // Ties resolve to 0.
    for (int i = 0; i < 4; i++) begin
      c0_tab[i] = 4'd6;
      c1_tab[i] = 4'd6;
    end
    run_eval(4'b1001, 0);
    check_eq("tie_resp", 32'({resp, sat_err}), 32'(3'b000));

    // Saturated counter on bit 1.
    c0_tab[2] = 4'd15;
    run_eval(4'b1001, 2);
    check_eq("sat_resp", 32'({resp, sat_err}), 32'(3'b101));

    for (int n = 0; n < 8; n++) begin
      for (int i = 0; i < 4; i++) begin
        c0_tab[i] = 4'($urandom_range(0, 15));
        c1_tab[i] = 4'($urandom_range(0, 15));
      end
      run_eval(4'($urandom), $urandom_range(0, 3));
    end

    for (int i = 0; i < 4; i++) begin
      c0_tab[i] = 4'($urandom_range(0, 15));
      c1_tab[i] = 4'($urandom_range(0, 15));
    end
    abort_eval(4'b0110);
    run_eval(4'b0110, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
